// File: rtl/hazard_pkg.sv
// Shared definitions for the decode hazard controller.
//   ADDR_W       register index width
//   CNT_W        default pending-write counter width (cnt_t)
//   BUSY_W       width of the busy-register count
//   state_t      issue sequencer states {RUN, FLUSH}
package hazard_pkg;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int BUSY_W = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage handshake between the decoder (master) and the hazard
// controller (slave).
//   dec_valid/dec_rs1/dec_rs1_used/dec_rs2/dec_rs2_used/dec_rd/dec_rd_write
//       instruction held in decode (master -> slave)
//   stall   hold decode, drives the decoder's rs_read (slave -> master)
//   issue   decode instruction accepted this cycle (slave -> master)
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rs1;
    logic              dec_rs1_used;
    logic [ADDR_W-1:0] dec_rs2;
    logic              dec_rs2_used;
    logic [ADDR_W-1:0] dec_rd;
    logic              dec_rd_write;
    logic              stall;
    logic              issue;

    modport master (
        output dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
               dec_rd, dec_rd_write,
        input  stall, issue
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
               dec_rd, dec_rd_write,
        output stall, issue
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters for the hazard controller.
//   clk, reset       clock, synchronous active-high reset
//   inc_valid/inc_rd issued instruction claims a destination
//   wb_valid/wb_rd   writeback retires a destination
//   kill_valid/kill_rd squashed writer, its writeback never arrives
//   rd_a/rd_b/rd_c   lookup indices, cnt_a/cnt_b/cnt_c current counts
//   busy_count       registers with a nonzero counter (after update)
//   err              sticky: a counter was decremented below zero
// x0 is never tracked; its counter is held at zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = hazard_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              kill_valid,
    input  logic [ADDR_W-1:0] kill_rd,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    input  logic [ADDR_W-1:0] rd_c,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_c,
    output logic [BUSY_W-1:0] busy_count,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREGS];
    logic [CNT_W-1:0]  cnt_d [NREGS];
    logic [BUSY_W-1:0] busy_d;
    logic              underflow;
    int                nxt;

    // Increment and both decrements are summed so that coincident events on
    // one register net out (issue+wb = unchanged, wb+kill = -2).
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch.
        underflow = 1'b0;
        busy_d    = '0;
        nxt       = 0;
        cnt_d[0]  = '0;
        for (int r = 1; r < NREGS; r++) begin
            nxt = int'(cnt_q[r])
                + ((inc_valid  && inc_rd  == ADDR_W'(r)) ? 1 : 0)
                - ((wb_valid   && wb_rd   == ADDR_W'(r)) ? 1 : 0)
                - ((kill_valid && kill_rd == ADDR_W'(r)) ? 1 : 0);
            if (nxt < 0) begin
                cnt_d[r]  = '0;
                underflow = 1'b1;
            end else if (nxt > int'(CNT_MAX)) begin
                cnt_d[r] = CNT_MAX;
            end else begin
                cnt_d[r] = CNT_W'(nxt);
            end
            if (cnt_d[r] != '0) begin
                busy_d = busy_d + BUSY_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is reset because hazard detection reads
            // it in the very first cycle after reset.
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_count <= '0;
            err        <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_count <= busy_d;
            err        <= err | underflow;
        end
    end

    assign cnt_a = cnt_q[rd_a];
    assign cnt_b = cnt_q[rd_b];
    assign cnt_c = cnt_q[rd_c];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stalls decode on RAW hazards against
// in-flight writes or on a saturated destination counter, and blocks issue
// for FLUSH_CYCLES cycles after a taken branch.
//   clk, reset     clock, synchronous active-high reset
//   dec_if         decode handshake (hazard_ctrl_if.slave): instruction in,
//                  stall/issue out (both combinational, same cycle)
//   wb_valid/wb_rd retiring register write
//   kill_valid/kill_rd squashed in-flight writer
//   branch_taken   taken branch resolved this cycle
//   flush          squash fetch/decode contents
//   busy_count     registered count of registers with pending writes
//   err            sticky counter-underflow flag
// Build option: define BYPASS_EN for a write-through register file, where a
// source whose last pending write retires this cycle is not a hazard.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREGS        = 32,
    parameter int CNT_W        = hazard_pkg::CNT_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    hazard_ctrl_if.slave      dec_if,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              kill_valid,
    input  logic [ADDR_W-1:0] kill_rd,
    input  logic              branch_taken,
    output logic              flush,
    output logic [BUSY_W-1:0] busy_count,
    output logic              err
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic             rs1_bypass, rs2_bypass;
    logic             rs1_haz, rs2_haz, rd_haz, hazard, run_ok;

    hazard_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .inc_valid  (dec_if.issue && dec_if.dec_rd_write),
        .inc_rd     (dec_if.dec_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .kill_valid (kill_valid),
        .kill_rd    (kill_rd),
        .rd_a       (dec_if.dec_rs1),
        .rd_b       (dec_if.dec_rs2),
        .rd_c       (dec_if.dec_rd),
        .cnt_a      (rs1_cnt),
        .cnt_b      (rs2_cnt),
        .cnt_c      (rd_cnt),
        .busy_count (busy_count),
        .err        (err)
    );

    always_comb begin
`ifdef BYPASS_EN
        rs1_bypass = wb_valid && wb_rd == dec_if.dec_rs1 && rs1_cnt == CNT_W'(1);
        rs2_bypass = wb_valid && wb_rd == dec_if.dec_rs2 && rs2_cnt == CNT_W'(1);
`else
        rs1_bypass = 1'b0;
        rs2_bypass = 1'b0;
`endif
        rs1_haz = dec_if.dec_rs1_used && dec_if.dec_rs1 != '0
                  && rs1_cnt != '0 && !rs1_bypass;
        rs2_haz = dec_if.dec_rs2_used && dec_if.dec_rs2 != '0
                  && rs2_cnt != '0 && !rs2_bypass;
        // A saturated counter cannot record another in-flight write.
        rd_haz  = dec_if.dec_rd_write && dec_if.dec_rd != '0 && rd_cnt == '1;
        hazard  = dec_if.dec_valid && (rs1_haz || rs2_haz || rd_haz);
    end

    // Reset masks the combinational outputs so nothing leaks during reset.
    assign run_ok       = !reset && state_q == RUN && !branch_taken;
    assign dec_if.issue = dec_if.dec_valid && !hazard && run_ok;
    assign dec_if.stall = hazard && run_ok;
    assign flush        = !reset && (state_q == FLUSH || branch_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The flush window counts down the cycles after the branch cycle;
    // another taken branch restarts it.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FC_LOAD;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    flush_cnt_d = FC_LOAD;
                end else if (flush_cnt_q <= FC_W'(1)) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

endmodule
